// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the pipeline, the memory arbiter and the unified memory.
// slave is the arbiter's view; master is the pipeline-plus-memory side that drives it.
interface mem_arbiter_if;
  localparam int unsigned W = 16;

  logic         i_req;
  logic [W-1:0] i_addr;
  logic         i_flush;
  logic         i_done;
  logic [W-1:0] i_rdata;
  logic         i_stall;

  logic         d_req;
  logic         d_wr;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic         d_done;
  logic [W-1:0] d_rdata;
  logic         d_stall;

  logic         m_en;
  logic         m_wr;
  logic [W-1:0] m_addr;
  logic [W-1:0] m_wdata;
  logic [W-1:0] m_rdata;
  logic         m_done;

  logic         busy;

  modport slave (
    input  i_req, i_addr, i_flush,
    input  d_req, d_wr, d_addr, d_wdata,
    input  m_rdata, m_done,
    output i_done, i_rdata, i_stall,
    output d_done, d_rdata, d_stall,
    output m_en, m_wr, m_addr, m_wdata,
    output busy
  );

  modport master (
    output i_req, i_addr, i_flush,
    output d_req, d_wr, d_addr, d_wdata,
    output m_rdata, m_done,
    input  i_done, i_rdata, i_stall,
    input  d_done, d_rdata, d_stall,
    input  m_en, m_wr, m_addr, m_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory between fetch and data; data wins unless fetch has
// waited through STREAK consecutive data grants. Supports cancelling an in-flight fetch.
module mem_arbiter #(
  parameter int unsigned STREAK = 4
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = (STREAK < 1) ? 1 : $clog2(STREAK + 1);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, I_DROP} state_t;

  state_t          state, state_d;
  logic [SW-1:0]   streak, streak_d;
  logic            m_en_q, m_en_d;
  logic            m_wr_q, m_wr_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic            i_done_w, d_done_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      m_en_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state     <= state_d;
      streak    <= streak_d;
      m_en_q    <= m_en_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  // Grant decision in IDLE; every busy state returns to IDLE on m_done.
  always_comb begin
    state_d   = state;
    streak_d  = streak;
    m_en_d    = 1'b0;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    case (state)
      IDLE: begin
        if (bus.d_req && (!bus.i_req || (streak < SW'(STREAK)))) begin
          state_d   = D_BUSY;
          m_en_d    = 1'b1;
          m_wr_d    = bus.d_wr;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          streak_d  = bus.i_req ? streak + SW'(1) : '0;
        end else if (bus.i_req) begin
          state_d  = I_BUSY;
          m_en_d   = 1'b1;
          m_wr_d   = 1'b0;
          m_addr_d = bus.i_addr;
          streak_d = '0;
        end
      end
      I_BUSY: begin
        if (bus.m_done)       state_d = IDLE;
        else if (bus.i_flush) state_d = I_DROP;
      end
      D_BUSY, I_DROP: begin
        if (bus.m_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion is same-cycle with m_done; reset masks it so an abandoned op never completes.
  assign i_done_w = !rst && (state == I_BUSY) && bus.m_done && !bus.i_flush;
  assign d_done_w = !rst && (state == D_BUSY) && bus.m_done;

  assign bus.i_done  = i_done_w;
  assign bus.d_done  = d_done_w;
  assign bus.i_rdata = i_done_w ? bus.m_rdata : '0;
  assign bus.d_rdata = d_done_w ? bus.m_rdata : '0;
  assign bus.i_stall = !rst && bus.i_req && !i_done_w;
  assign bus.d_stall = !rst && bus.d_req && !d_done_w;

  assign bus.m_en    = m_en_q;
  assign bus.m_wr    = m_wr_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.busy    = (state != IDLE);
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-port, multi-cycle unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes). Requests are level-held until a one-cycle done pulse. Data has fixed priority over fetch, with a streak limit so fetch cannot starve. The block drives per-requester stall lines that feed the pipeline hazard logic. It supports cancelling an in-flight fetch on a taken branch.

## Interface
- STREAK, default 4: maximum consecutive data grants issued while a fetch request is waiting.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch read request; held until i_done.
- i_addr  in  16  fetch address.
- i_flush  in  1  taken branch; cancels the in-flight fetch.
- i_done  out  1  one-cycle pulse; i_rdata is valid in this cycle.
- i_rdata  out  16  fetch read data.
- i_stall  out  1  fetch must hold its PC.
- d_req  in  1  data request; held until d_done.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  16  data address.
- d_wdata  in  16  write data.
- d_done  out  1  one-cycle pulse; d_rdata is valid in this cycle for reads.
- d_rdata  out  16  data read data.
- d_stall  out  1  memory stage must hold.
- m_en  out  1  one-cycle issue strobe to memory.
- m_wr  out  1  write qualifier for m_en.
- m_addr  out  16  latched address.
- m_wdata  out  16  latched write data.
- m_rdata  in  16  memory read data; valid when m_done is high.
- m_done  in  1  one-cycle completion pulse; arrives at least 1 cycle after m_en.
- busy  out  1  state is not IDLE.

## Operation
- **States:** IDLE, I_BUSY, D_BUSY, I_DROP.
- **IDLE, grant decision:**
  - d_req=1, and either i_req=0 or streak<STREAK → D_BUSY.
  - Otherwise i_req=1 → I_BUSY.
  - On a grant, latch address/wr/wdata into m_addr/m_wr/m_wdata and pulse m_en for exactly one cycle.
  - An I grant sets m_wr=0.
- **I_BUSY:**
  - m_done & ~i_flush → i_done=1, i_rdata=m_rdata; next state IDLE.
  - i_flush & ~m_done → I_DROP.
  - i_flush & m_done in the same cycle → i_done suppressed; next state IDLE.
- **I_DROP:** wait for m_done; discard the data; i_done stays 0; next state IDLE.
- **D_BUSY:** m_done → d_done=1, d_rdata=m_rdata; next state IDLE. i_flush is ignored in this state.
- **i_flush outside I_BUSY:** no effect.
- **Minimum idle:** after any completion the FSM spends at least one cycle in IDLE, so a requester can drop req after its done.
- **Streak counter** (saturating, 0..STREAK):
  - D grant with i_req=1 → increment.
  - D grant with i_req=0 → clear.
  - I grant → clear.
- **Stalls** (combinational; both forced 0 while rst=1):
  - i_stall = i_req & ~i_done.
  - d_stall = d_req & ~d_done.
- **Data passthrough:** i_rdata/d_rdata show m_rdata whenever their done is high. Otherwise they hold 0.
- **m_done** received in IDLE is ignored.

## Timing
- **Reset values:**
  - state=IDLE, streak=0.
  - m_en, m_wr = 0.
  - m_addr, m_wdata = 0.
  - i_done, d_done = 0.
  - busy = 0.
  - i_rdata, d_rdata = 0.
- **Reset mid-operation:** the transaction is abandoned and no done pulse is issued. The memory shares rst, so any late m_done is ignored because it arrives in IDLE.
- **Issue latency:** req is sampled in IDLE at edge N; m_en is high in cycle N+1 (registered output).
- **Done latency:** done is combinational on m_done, in the same cycle. Minimum request-to-done is 2 cycles.
- **Throughput:** at most one transaction per 3 cycles (issue, ≥1 wait, IDLE).
- **Address stability:** m_addr/m_wdata/m_wr stay stable from m_en until the completion edge.
- **Request changes:** changes to req/addr during BUSY have no effect until the next IDLE.

## Test plan
- **Single fetch:** i_req=1, i_addr=0x0010, memory done 2 cycles after m_en with 0x1234 → m_en one cycle with m_addr=0x0010, m_wr=0; i_done with i_rdata=0x1234; i_stall=1 up to and including the cycle before done.
- **Collision:** i_req and d_req rise together, d_wr=1, d_addr=0x0100, d_wdata=0xBEEF → D granted first (m_wr=1, m_wdata=0xBEEF); after d_done and one IDLE cycle, I is granted.
- **Streak:** d_req held high for back-to-back requests and i_req held high, STREAK=4 → grant order D,D,D,D,I,D; streak clears after the I grant.
- **Flush:** i_flush pulses one cycle after m_en of a fetch, m_done 3 cycles later → state I_DROP; no i_done; busy=1 until m_done; next grant only after IDLE.
- **Flush coincident with m_done:** i_flush and m_done in the same cycle → i_done=0; state IDLE next cycle.
- **Reset mid-op:** assert rst during D_BUSY → next cycle all outputs at reset values; d_done never pulses; a stray m_done after reset produces no done.
